// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one memory port between fetch and data channels.
// Data wins unless a fetch has waited through MAX_D_STREAK data grants.
module mem_bus_arbiter #(
  parameter int BIT_WIDTH    = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64,
  parameter logic [BIT_WIDTH-1:0] ERR_DATA = 32'hdeadbeef
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [BIT_WIDTH-1:0] IAD,
  output logic [BIT_WIDTH-1:0] IDT,
  output logic                 ACKI_n,
  input  logic                 MREQ,
  input  logic                 WRITE,
  input  logic [1:0]           SIZE,
  input  logic [BIT_WIDTH-1:0] DAD,
  input  logic [BIT_WIDTH-1:0] d_wdata,
  output logic [BIT_WIDTH-1:0] d_rdata,
  output logic                 ACKD_n,
  output logic                 bus_err,
  output logic                 m_req,
  output logic                 m_write,
  output logic [1:0]           m_size,
  output logic [BIT_WIDTH-1:0] m_addr,
  output logic [BIT_WIDTH-1:0] m_wdata,
  input  logic [BIT_WIDTH-1:0] m_rdata,
  input  logic                 m_ack_n
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE, IBUSY, DBUSY, DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 m_req_q, m_req_d;
  logic                 m_write_q, m_write_d;
  logic [1:0]           m_size_q, m_size_d;
  logic [BIT_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [BIT_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [BIT_WIDTH-1:0] idt_q, idt_d;
  logic [BIT_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                 acki_n_q, acki_n_d;
  logic                 ackd_n_q, ackd_n_d;
  logic                 bus_err_q, bus_err_d;
  logic [SW-1:0]        streak_q, streak_d;
  logic [TW-1:0]        timer_q, timer_d;

  logic                 d_win;
  logic                 fin;
  logic                 tmo;
  logic [BIT_WIDTH-1:0] rdata;

  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_write_d = m_write_q;
    m_size_d  = m_size_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    idt_d     = idt_q;
    d_rdata_d = d_rdata_q;
    acki_n_d  = 1'b1;
    ackd_n_d  = 1'b1;
    bus_err_d = 1'b0;
    streak_d  = streak_q;
    timer_d   = timer_q;
    d_win = MREQ &&
      (!i_req || streak_q < SW'(MAX_D_STREAK));
    // an ack on the timeout edge takes precedence
    tmo   = m_ack_n && timer_q == TW'(TIMEOUT - 1);
    fin   = !m_ack_n || tmo;
    rdata = m_ack_n ? ERR_DATA : m_rdata;
    unique case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d   = DBUSY;
          m_req_d   = 1'b1;
          m_write_d = WRITE;
          m_size_d  = SIZE;
          m_addr_d  = DAD;
          m_wdata_d = d_wdata;
          timer_d   = '0;
          streak_d  = i_req ? streak_q + SW'(1) : '0;
        end else if (i_req) begin
          state_d   = IBUSY;
          m_req_d   = 1'b1;
          m_write_d = 1'b0;
          m_size_d  = 2'b00;
          m_addr_d  = IAD;
          timer_d   = '0;
          streak_d  = '0;
        end else begin
          streak_d  = '0;
        end
      end
      IBUSY, DBUSY: begin
        if (fin) begin
          state_d   = DONE;
          m_req_d   = 1'b0;
          bus_err_d = tmo;
          if (state_q == IBUSY) begin
            idt_d    = rdata;
            acki_n_d = 1'b0;
          end else begin
            d_rdata_d = rdata;
            ackd_n_d  = 1'b0;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_write_q <= 1'b0;
      m_size_q  <= 2'b00;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      idt_q     <= '0;
      d_rdata_q <= '0;
      acki_n_q  <= 1'b1;
      ackd_n_q  <= 1'b1;
      bus_err_q <= 1'b0;
      streak_q  <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_write_q <= m_write_d;
      m_size_q  <= m_size_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      idt_q     <= idt_d;
      d_rdata_q <= d_rdata_d;
      acki_n_q  <= acki_n_d;
      ackd_n_q  <= ackd_n_d;
      bus_err_q <= bus_err_d;
      streak_q  <= streak_d;
      timer_q   <= timer_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_write = m_write_q;
  assign m_size  = m_size_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign IDT     = idt_q;
  assign d_rdata = d_rdata_q;
  assign ACKI_n  = acki_n_q;
  assign ACKD_n  = ackd_n_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: core drivers, memory model,
// ack monitor and grant checker fed by hand-computed expectations.
module tb_mem_bus_arbiter;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    logic        err;
  } ack_t;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
  } gnt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] IAD = '0;
  logic [31:0] IDT;
  logic        ACKI_n;
  logic        MREQ = 1'b0;
  logic        WRITE = 1'b0;
  logic [1:0]  SIZE = 2'b00;
  logic [31:0] DAD = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        ACKD_n;
  logic        bus_err;
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack_n = 1'b1;

  int   n_vec = 0;
  int   n_err = 0;
  ack_t ack_q[$];
  gnt_t gnt_q[$];
  int   mem_delay = 0;
  bit   mem_noack = 0;
  int   busy_cnt = 0;
  int   last_len = 0;
  bit   m_req_prev = 0;
  gnt_t cur;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .IAD(IAD), .IDT(IDT),
    .ACKI_n(ACKI_n),
    .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
    .DAD(DAD), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .ACKD_n(ACKD_n),
    .bus_err(bus_err),
    .m_req(m_req), .m_write(m_write),
    .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata),
    .m_ack_n(m_ack_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(
    input logic [31:0] a);
    return (a == 32'h100) ? 32'h13
                          : a ^ 32'h5a5a0000;
  endfunction

  // memory model and grant checker
  always @(negedge clk) begin
    if (m_req) begin
      if (!m_req_prev) begin
        busy_cnt = 0;
        n_vec++;
        if (gnt_q.size() == 0) begin
          n_err++;
          $display("FAIL grant: unexpected a=%h",
                   m_addr);
          cur = '{m_write, m_size, m_addr, m_wdata};
        end else begin
          cur = gnt_q.pop_front();
          n_vec--;
          chk("grant_w", 32'(m_write), 32'(cur.w));
          chk("grant_sz", 32'(m_size), 32'(cur.sz));
          chk("grant_a", m_addr, cur.a);
          if (cur.w)
            chk("grant_wd", m_wdata, cur.wd);
        end
      end else begin
        chk("hold_a", m_addr, cur.a);
        chk("hold_w", 32'(m_write), 32'(cur.w));
      end
      if (!mem_noack && busy_cnt == mem_delay) begin
        m_ack_n = 1'b0;
        m_rdata = mem_word(m_addr);
      end else begin
        m_ack_n = 1'b1;
      end
      busy_cnt++;
    end else begin
      if (m_req_prev) last_len = busy_cnt;
      m_ack_n = 1'b1;
      busy_cnt = 0;
    end
    m_req_prev = m_req;
  end

  // ack monitor
  always @(negedge clk) begin
    if (rst && (!ACKI_n || !ACKD_n)) begin
      if (!ACKI_n && !ACKD_n) begin
        n_vec++;
        n_err++;
        $display("FAIL ack_both: got 2 acks want 1");
      end else if (ack_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL ack_extra: got ack want none");
      end else begin
        ack_t e;
        e = ack_q.pop_front();
        chk("ack_chan", 32'(!ACKD_n), 32'(e.is_d));
        chk("ack_data", !ACKD_n ? d_rdata : IDT,
            e.data);
        chk("ack_err", 32'(bus_err), 32'(e.err));
      end
    end
  end

  task automatic wait_ack(input bit d, input string nm);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (d ? !ACKD_n : !ACKI_n) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: got no ack want ack", nm);
  endtask

  task automatic data_req(input logic w,
                          input logic [1:0] sz,
                          input logic [31:0] a,
                          input logic [31:0] wd);
    MREQ = 1'b1;
    WRITE = w;
    SIZE = sz;
    DAD = a;
    d_wdata = wd;
    wait_ack(1'b1, "data_timeout");
    MREQ = 1'b0;
  endtask

  task automatic fetch_req(input logic [31:0] a);
    i_req = 1'b1;
    IAD = a;
    wait_ack(1'b0, "fetch_timeout");
    i_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_acki", 32'(ACKI_n), 1);
    chk("rst_ackd", 32'(ACKD_n), 1);
    chk("rst_err", 32'(bus_err), 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_idt", IDT, 0);

    // 1: fetch straight out of reset
    i_req = 1'b1;
    IAD = 32'h100;
    gnt_q.push_back('{0, 2'b00, 32'h100, 0});
    ack_q.push_back('{0, 32'h13, 0});
    rst = 1'b1;
    fork
      fetch_req(32'h100);
      begin
        @(posedge clk);
        #1;
        chk("t1_m_req", 32'(m_req), 1);
      end
    join
    idle(3);

    // 2: simultaneous requests, data first
    gnt_q.push_back('{0, 2'b00, 32'h2000, 0});
    gnt_q.push_back('{0, 2'b00, 32'h300, 0});
    ack_q.push_back('{1, 32'h5a5a2000, 0});
    ack_q.push_back('{0, 32'h5a5a0300, 0});
    fork
      data_req(0, 2'b00, 32'h2000, 0);
      fetch_req(32'h300);
    join
    idle(3);

    // 3: data streak limit lets one fetch in
    for (int k = 0; k < 4; k++) begin
      gnt_q.push_back('{0, 2'b00,
                        32'h3000 + 32'(4 * k), 0});
    end
    gnt_q.push_back('{0, 2'b00, 32'h400, 0});
    gnt_q.push_back('{0, 2'b00, 32'h3010, 0});
    gnt_q.push_back('{0, 2'b00, 32'h3014, 0});
    ack_q.push_back('{1, 32'h5a5a3000, 0});
    ack_q.push_back('{1, 32'h5a5a3004, 0});
    ack_q.push_back('{1, 32'h5a5a3008, 0});
    ack_q.push_back('{1, 32'h5a5a300c, 0});
    ack_q.push_back('{0, 32'h5a5a0400, 0});
    ack_q.push_back('{1, 32'h5a5a3010, 0});
    ack_q.push_back('{1, 32'h5a5a3014, 0});
    fork
      for (int k = 0; k < 6; k++)
        data_req(0, 2'b00, 32'h3000 + 32'(4 * k), 0);
      fetch_req(32'h400);
    join
    idle(3);

    // 4: store held stable while inputs wander
    mem_delay = 3;
    gnt_q.push_back('{1, 2'b10, 32'hf0000000,
                      32'h41});
    ack_q.push_back('{1, 32'haa5a0000, 0});
    fork
      data_req(1, 2'b10, 32'hf0000000, 32'h41);
      begin
        idle(2);
        DAD = 32'h1234;
        WRITE = 1'b0;
        d_wdata = '0;
      end
    join
    idle(3);

    // 5: never acknowledged -> timeout
    mem_noack = 1;
    gnt_q.push_back('{0, 2'b01, 32'h6000, 0});
    ack_q.push_back('{1, 32'hdeadbeef, 1});
    data_req(0, 2'b01, 32'h6000, 0);
    idle(2);
    chk("t5_busy_len", 32'(last_len), 64);

    // ack on the timeout edge wins
    mem_noack = 0;
    mem_delay = 63;
    gnt_q.push_back('{0, 2'b00, 32'h4000, 0});
    ack_q.push_back('{1, 32'h5a5a4000, 0});
    data_req(0, 2'b00, 32'h4000, 0);
    idle(2);
    chk("tb_busy_len", 32'(last_len), 64);
    chk("tb_rdata", d_rdata, 32'h5a5a4000);

    // 6: reset mid-access
    mem_noack = 1;
    gnt_q.push_back('{0, 2'b01, 32'h5000, 0});
    MREQ = 1'b1;
    WRITE = 1'b0;
    SIZE = 2'b01;
    DAD = 32'h5000;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("t6_m_req", 32'(m_req), 0);
    chk("t6_ackd", 32'(ACKD_n), 1);
    chk("t6_err", 32'(bus_err), 0);
    chk("t6_addr", m_addr, 0);
    chk("t6_size", 32'(m_size), 0);
    chk("t6_rdata", d_rdata, 0);
    chk("t6_idt", IDT, 0);
    MREQ = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(10);
    chk("left_acks", 32'(ack_q.size()), 0);
    chk("left_grants", 32'(gnt_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
